// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: flags PATTERN or a run of PAT_LEN equal bits.
// Optional saturating match counter compiled in with `define SEQDET_COUNT_EN.
module seq_detect_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8,
  localparam int                FILL_W  = $clog2(PAT_LEN + 1)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              en,
  input  logic              w,
  input  logic              mode,
  input  logic              ovl,
  output logic              z,
  output logic [FILL_W-1:0] fill
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]  match_cnt
`endif
);

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] r_win;
  logic [FILL_W-1:0]  r_fill;
  logic               r_z;
  logic               r_modeQ;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]   r_cnt;
`endif

  logic [PAT_LEN-1:0] w_cand;
  logic               w_valid;
  logic               w_modeChg;
  logic               w_hit;
  logic               w_match;

  // Candidate is the window as it would look after shifting in the current bit.
  assign w_cand    = {r_win[PAT_LEN-2:0], w};
  assign w_valid   = (r_fill >= FILL_NEED);
  assign w_modeChg = (mode != r_modeQ);
  assign w_hit     = mode ? ((&w_cand) | (~|w_cand)) : (w_cand == PATTERN);
  assign w_match   = en & ~w_modeChg & w_valid & w_hit;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_win   <= '0;
      r_fill  <= '0;
      r_z     <= 1'b0;
      r_modeQ <= mode;
`ifdef SEQDET_COUNT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_z <= 1'b0;
      if (en) begin
        r_win <= w_cand;
        // A mode switch restarts the fill so a match needs PAT_LEN bits seen under the new mode.
        if (w_modeChg) begin
          r_fill  <= '0;
          r_modeQ <= mode;
        end else if (w_match) begin
          r_z    <= 1'b1;
          r_fill <= ovl ? FILL_MAX : '0;
`ifdef SEQDET_COUNT_EN
          if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end else if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
    end
  end

  assign z    = r_z;
  assign fill = r_fill;
`ifdef SEQDET_COUNT_EN
  assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param (PAT_LEN=4, PATTERN=1011, CNT_W=2).
// Counter checks are active only when SEQDET_COUNT_EN is defined.
module tb_seq_detect_param;

  logic       Clock;
  logic       Resetn;
  logic       en;
  logic       w;
  logic       mode;
  logic       ovl;
  logic       z;
  logic [2:0] fill;
`ifdef SEQDET_COUNT_EN
  logic [1:0] match_cnt;
`endif

  seq_detect_param #(
    .PAT_LEN(4),
    .PATTERN(4'b1011),
    .CNT_W  (2)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .en    (en),
    .w     (w),
    .mode  (mode),
    .ovl   (ovl),
    .z     (z),
    .fill  (fill)
`ifdef SEQDET_COUNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       rstn;
    logic       en;
    logic       w;
    logic       mode;
    logic       ovl;
    logic       expZ;
    logic [2:0] expFill;
    logic [1:0] expCnt;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int   numChecks = 0;
  int   numFails  = 0;
  int   stepNo    = 0;
  string curName;

  task automatic addVec(input logic rstn, input logic e, input logic b, input logic m,
                        input logic o, input logic ez, input int ef, input int ec);
    vec_t v;
    v.rstn = rstn; v.en = e; v.w = b; v.mode = m; v.ovl = o;
    v.expZ = ez; v.expFill = 3'(ef); v.expCnt = 2'(ec);
    vecs.push_back(v);
  endtask

  // Drive one record on the falling edge and queue what the DUT must show after the next rise.
  task automatic applyStimulus(input vec_t v);
    @(negedge Clock);
    Resetn = v.rstn;
    en     = v.en;
    w      = v.w;
    mode   = v.mode;
    ovl    = v.ovl;
    expQ.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    @(posedge Clock);
    #1;
    stepNo++;
    if (expQ.size() == 0) begin
      numChecks++;
      numFails++;
      $display("[TB] FAIL %s step %0d: scoreboard empty, got nothing want one entry", curName, stepNo);
      return;
    end
    e = expQ.pop_front();
    numChecks++;
    if (z !== e.expZ) begin
      numFails++;
      $display("[TB] FAIL %s step %0d z: got %0b want %0b", curName, stepNo, z, e.expZ);
    end
    numChecks++;
    if (fill !== e.expFill) begin
      numFails++;
      $display("[TB] FAIL %s step %0d fill: got %0d want %0d", curName, stepNo, fill, e.expFill);
    end
`ifdef SEQDET_COUNT_EN
    numChecks++;
    if (match_cnt !== e.expCnt) begin
      numFails++;
      $display("[TB] FAIL %s step %0d match_cnt: got %0d want %0d", curName, stepNo, match_cnt, e.expCnt);
    end
`endif
  endtask

  task automatic step(input logic rstn, input logic e, input logic b, input logic m,
                      input logic o, input logic ez, input int ef, input int ec);
    vec_t v;
    v.rstn = rstn; v.en = e; v.w = b; v.mode = m; v.ovl = o;
    v.expZ = ez; v.expFill = 3'(ef); v.expCnt = 2'(ec);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    Resetn = 1'b0; en = 1'b1; w = 1'b1; mode = 1'b0; ovl = 1'b1;

    // Reset held two edges, then pattern stream with overlap: hits on samples 4 and 7.
    addVec(0,1,1,0,1, 0,0,0);
    addVec(0,1,1,0,1, 0,0,0);
    addVec(1,1,1,0,1, 0,1,0);
    addVec(1,1,0,0,1, 0,2,0);
    addVec(1,1,1,0,1, 0,3,0);
    addVec(1,1,1,0,1, 1,4,1);
    addVec(1,1,0,0,1, 0,4,1);
    addVec(1,1,1,0,1, 0,4,1);
    addVec(1,1,1,0,1, 1,4,2);
    // Same stream without overlap: one hit, fill restarts from zero.
    addVec(0,1,0,0,0, 0,0,0);
    addVec(1,1,1,0,0, 0,1,0);
    addVec(1,1,0,0,0, 0,2,0);
    addVec(1,1,1,0,0, 0,3,0);
    addVec(1,1,1,0,0, 1,0,1);
    addVec(1,1,0,0,0, 0,1,1);
    addVec(1,1,1,0,0, 0,2,1);
    addVec(1,1,1,0,0, 0,3,1);
    // Run mode with overlap, ones then zeros; five hits saturate the 2-bit counter.
    addVec(0,1,1,1,1, 0,0,0);
    addVec(1,1,1,1,1, 0,1,0);
    addVec(1,1,1,1,1, 0,2,0);
    addVec(1,1,1,1,1, 0,3,0);
    addVec(1,1,1,1,1, 1,4,1);
    addVec(1,1,1,1,1, 1,4,2);
    addVec(1,1,1,1,1, 1,4,3);
    addVec(1,1,0,1,1, 0,4,3);
    addVec(1,1,0,1,1, 0,4,3);
    addVec(1,1,0,1,1, 0,4,3);
    addVec(1,1,0,1,1, 1,4,3);
    addVec(1,1,0,1,1, 1,4,3);
    // Run mode without overlap: hits only on samples 4 and 10.
    addVec(0,1,1,1,0, 0,0,0);
    addVec(1,1,1,1,0, 0,1,0);
    addVec(1,1,1,1,0, 0,2,0);
    addVec(1,1,1,1,0, 0,3,0);
    addVec(1,1,1,1,0, 1,0,1);
    addVec(1,1,1,1,0, 0,1,1);
    addVec(1,1,1,1,0, 0,2,1);
    addVec(1,1,0,1,0, 0,3,1);
    addVec(1,1,0,1,0, 0,4,1);
    addVec(1,1,0,1,0, 0,4,1);
    addVec(1,1,0,1,0, 1,0,2);

    curName = "table";
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Enable gaps: junk bits on en=0 edges are ignored and z stays low there.
    curName = "en_gaps";
    step(0,1,0,0,1, 0,0,0);
    step(1,1,1,0,1, 0,1,0);
    step(1,0,1,0,1, 0,1,0);
    step(1,1,0,0,1, 0,2,0);
    step(1,0,0,0,1, 0,2,0);
    step(1,1,1,0,1, 0,3,0);
    step(1,0,0,0,1, 0,3,0);
    step(1,1,1,0,1, 1,4,1);
    step(1,0,1,0,1, 0,4,1);

    // Mode flip after three bits: the would-be run hit is suppressed, four fresh samples needed.
    curName = "mode_flip";
    step(0,1,0,0,1, 0,0,0);
    step(1,1,1,0,1, 0,1,0);
    step(1,1,1,0,1, 0,2,0);
    step(1,1,1,0,1, 0,3,0);
    step(1,1,1,1,1, 0,0,0);
    step(1,1,1,1,1, 0,1,0);
    step(1,1,1,1,1, 0,2,0);
    step(1,1,1,1,1, 0,3,0);
    step(1,1,1,1,1, 1,4,1);
    step(1,1,1,1,1, 1,4,2);

    // Reset mid-pattern discards progress and the counter.
    curName = "mid_reset";
    step(1,1,0,0,1, 0,0,2);
    step(1,1,1,0,1, 0,1,2);
    step(1,1,0,0,1, 0,2,2);
    step(1,1,1,0,1, 0,3,2);
    step(0,1,1,0,1, 0,0,0);
    step(1,1,1,0,1, 0,1,0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
